uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter byte engine between NUM_REQ byte sources, using round-robin arbitration.
- Sequences the engine's control strobes: load_data_reg and transfer_byte together in one cycle, then byte_ready in the next cycle.
- Enforces the engine's fixed frame occupancy, so a new byte is never issued while a frame is in flight.
- Sits between the requesting blocks (CSR path, debug stream, etc.) and the transmitter; shares clk and rst with it.

---
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter byte engine between NUM_REQ sources.
// Sequences load/transfer then byte_ready, and holds off new issues for the frame occupancy.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned TX_OCCUPANCY = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [7:0]                 tx_data_in,
    output logic                       tx_load_data_reg,
    output logic                       tx_transfer_byte,
    output logic                       tx_byte_ready,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       done
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] WAIT_INIT = CW'(TX_OCCUPANCY - 4);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        ARM   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   wait_cnt;

    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [7:0]      grant_data;
    logic [IW-1:0]   next_ptr;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned k;
        k           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!grant_found && req_valid[IW'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(k);
            end
        end
    end

    // Byte of the winning requester.
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                grant_data = req_data[8*i +: 8];
            end
        end
    end

    assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);

    // Arbitration/sequencing FSM; every strobe is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ARB;
            rr_ptr           <= '0;
            wait_cnt         <= '0;
            req_ack          <= '0;
            tx_data_in       <= '0;
            tx_load_data_reg <= 1'b0;
            tx_transfer_byte <= 1'b0;
            tx_byte_ready    <= 1'b0;
            busy             <= 1'b0;
            owner            <= '0;
            done             <= 1'b0;
        end else begin
            req_ack          <= '0;
            tx_load_data_reg <= 1'b0;
            tx_transfer_byte <= 1'b0;
            tx_byte_ready    <= 1'b0;
            done             <= 1'b0;
            case (state)
                ARB: begin
                    if (en && grant_found) begin
                        tx_data_in       <= grant_data;
                        owner            <= grant_idx;
                        rr_ptr           <= next_ptr;
                        req_ack          <= NUM_REQ'(1) << grant_idx;
                        tx_load_data_reg <= 1'b1;
                        tx_transfer_byte <= 1'b1;
                        busy             <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_byte_ready <= 1'b1;
                    state         <= ARM;
                end
                ARM: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, issue spacing, enable and reset behaviour.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [7:0]  tx_data_in;
    logic        tx_load_data_reg;
    logic        tx_transfer_byte;
    logic        tx_byte_ready;
    logic        busy;
    logic [1:0]  owner;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int iss_cyc[$];
    int iss_idx[$];
    int iss_data[$];
    int iss_owner[$];

    uart_tx_arbiter #(.NUM_REQ(4), .TX_OCCUPANCY(12)) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ack          (req_ack),
        .tx_data_in       (tx_data_in),
        .tx_load_data_reg (tx_load_data_reg),
        .tx_transfer_byte (tx_transfer_byte),
        .tx_byte_ready    (tx_byte_ready),
        .busy             (busy),
        .owner            (owner),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue log taken on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (req_ack != 4'b0000) begin
                int idx;
                idx = 0;
                for (int i = 0; i < 4; i++) if (req_ack[i]) idx = i;
                check("ack_onehot", 32'($countones(req_ack)), 32'd1);
                check("issue_strobes", {30'd0, tx_load_data_reg, tx_transfer_byte}, 32'd3);
                iss_cyc.push_back(cyc);
                iss_idx.push_back(idx);
                iss_data.push_back(int'(tx_data_in));
                iss_owner.push_back(int'(owner));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        iss_cyc.delete();
        iss_idx.delete();
        iss_data.delete();
        iss_owner.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic reset_dut();
        rst       = 1'b0;
        req_valid = 4'b0000;
        step(2);
        clear_log();
        rst = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            step(1);
            k++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Compare logged issue i against expected owner/data, tolerating a short log.
    task automatic check_issue(input string tag, input int i, input int exp_idx, input int exp_data);
        int got_idx, got_owner, got_data;
        got_idx   = (i < iss_idx.size())   ? iss_idx[i]   : 99;
        got_owner = (i < iss_owner.size()) ? iss_owner[i] : 99;
        got_data  = (i < iss_data.size())  ? iss_data[i]  : 999;
        check({tag, "_ack"},   32'(got_idx),   32'(exp_idx));
        check({tag, "_owner"}, 32'(got_owner), 32'(exp_idx));
        check({tag, "_data"},  32'(got_data),  32'(exp_data));
    endtask

    initial begin
        int done_at;
        rst       = 1'b0;
        en        = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        step(2);
        check("rst_ack",     {28'd0, req_ack}, 32'd0);
        check("rst_data",    {24'd0, tx_data_in}, 32'd0);
        check("rst_strobes", {29'd0, tx_load_data_reg, tx_transfer_byte, tx_byte_ready}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_owner",   {30'd0, owner}, 32'd0);
        check("rst_done",    {31'd0, done}, 32'd0);

        // Single request from requester 0.
        reset_dut();
        en             = 1'b1;
        req_data[7:0]  = 8'hA5;
        req_valid      = 4'b0001;
        step(1);
        check("t1_ack",   {28'd0, req_ack}, 32'h1);
        check("t1_load",  {30'd0, tx_load_data_reg, tx_transfer_byte}, 32'd3);
        check("t1_data",  {24'd0, tx_data_in}, 32'hA5);
        check("t1_busy",  {31'd0, busy}, 32'd1);
        check("t1_br0",   {31'd0, tx_byte_ready}, 32'd0);
        req_valid = 4'b0000;
        step(1);
        check("t1_br1",   {31'd0, tx_byte_ready}, 32'd1);
        check("t1_arm",   {26'd0, req_ack, tx_load_data_reg, tx_transfer_byte}, 32'd0);
        done_at = 0;
        for (int k = 3; k <= 30; k++) begin
            step(1);
            if (done && done_at == 0) done_at = k;
        end
        check("t1_done_at", 32'(done_at), 32'd12);
        check("t1_busy_len", 32'(busy_cnt), 32'd11);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);

        // All four requesters continuously valid.
        reset_dut();
        en        = 1'b1;
        req_data  = 32'h13121110;
        req_valid = 4'b1111;
        step(55);
        req_valid = 4'b0000;
        wait_idle();
        check("t2_count", 32'(iss_idx.size()), 32'd5);
        check_issue("t2_g0", 0, 0, 8'h10);
        check_issue("t2_g1", 1, 1, 8'h11);
        check_issue("t2_g2", 2, 2, 8'h12);
        check_issue("t2_g3", 3, 3, 8'h13);
        check_issue("t2_g4", 4, 0, 8'h10);
        for (int i = 1; i < 5; i++) begin
            int gap;
            gap = (i < iss_cyc.size()) ? iss_cyc[i] - iss_cyc[i-1] : 0;
            check("t2_spacing", 32'(gap), 32'd12);
        end

        // Fairness: req2 arriving mid-frame beats req0's second byte.
        reset_dut();
        en        = 1'b1;
        req_data  = 32'h00220020;
        req_valid = 4'b0001;
        step(5);
        req_valid = 4'b0101;
        step(30);
        req_valid = 4'b0000;
        wait_idle();
        check("t3_count", 32'(iss_idx.size()), 32'd3);
        check_issue("t3_g0", 0, 0, 8'h20);
        check_issue("t3_g1", 1, 2, 8'h22);
        check_issue("t3_g2", 2, 0, 8'h20);

        // Enable low blocks grants; enable dropped mid-frame lets the frame finish.
        reset_dut();
        en        = 1'b0;
        req_data  = 32'h43424140;
        req_valid = 4'b1111;
        step(20);
        check("t4_no_issue", 32'(iss_idx.size()), 32'd0);
        check("t4_no_busy",  32'(busy_cnt), 32'd0);
        en = 1'b1;
        step(1);
        check("t4_ack", {28'd0, req_ack}, 32'h1);
        check("t4_owner", {30'd0, owner}, 32'd0);
        step(4);
        en = 1'b0;
        step(30);
        check("t5_issues", 32'(iss_idx.size()), 32'd1);
        check("t5_done",   32'(done_cnt), 32'd1);
        check("t5_idle",   {31'd0, busy}, 32'd0);

        // Reset in the 6th WAIT cycle, then req0 before req3.
        reset_dut();
        en        = 1'b1;
        req_data  = 32'h33000030;
        req_valid = 4'b1001;
        step(8);
        rst = 1'b0;
        #1;
        check("t6_busy",  {31'd0, busy}, 32'd0);
        check("t6_data",  {24'd0, tx_data_in}, 32'd0);
        check("t6_misc",  {26'd0, owner, done, tx_load_data_reg, tx_transfer_byte, tx_byte_ready}, 32'd0);
        step(1);
        clear_log();
        rst = 1'b1;
        step(20);
        req_valid = 4'b0000;
        wait_idle();
        check("t6_count", 32'(iss_idx.size()), 32'd2);
        check_issue("t6_g0", 0, 0, 8'h30);
        check_issue("t6_g1", 1, 3, 8'h33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
